// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, constants and price function for the vending sequencer
package vend_pkg;

  localparam int NUM_TYPES  = 8;
  localparam int TYPE_W     = 3;
  localparam int STOCK_W    = 4;
  localparam int INIT_STOCK = 5;
  localparam int STOCK_MAX  = 15;
  localparam int PRICE_BASE = 2;
  localparam int PRICE_STEP = 1;

  localparam int ERR_ZERO_AMT = 0;
  localparam int ERR_NO_STOCK = 1;
  localparam int ERR_NO_MONEY = 2;
  localparam int ERR_CLAMP    = 3;
  localparam int ERR_COLLIDE  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  function automatic logic [6:0] price(input logic [TYPE_W-1:0] t);
    return 7'(PRICE_BASE + int'(t) * PRICE_STEP);
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// rtl/vend_stock_bank.sv - per-type stock register file with saturating read-modify-write
module vend_stock_bank
  import vend_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [TYPE_W-1:0]  i_rd_type,
  output logic [STOCK_W-1:0] o_rd_data,
  input  logic               i_wr_en,
  input  logic               i_wr_add,
  input  logic [TYPE_W-1:0]  i_wr_type,
  input  logic [STOCK_W-1:0] i_wr_amount,
  output logic [STOCK_W-1:0] o_wr_level,
  output logic               o_wr_clamp
);

  localparam int SUM_W = STOCK_W + 1;

  logic [STOCK_W-1:0] r_stock [NUM_TYPES];
  logic [STOCK_W-1:0] w_level;
  logic [SUM_W-1:0]   w_update;

  // Result MSB flags saturation; lower bits are the new stock value.
  function automatic logic [SUM_W-1:0] sat_update(input logic [STOCK_W-1:0] cur,
                                                  input logic [STOCK_W-1:0] amt,
                                                  input logic               add);
    logic [SUM_W-1:0] sum;
    if (add) begin
      sum = {1'b0, cur} + {1'b0, amt};
      if (sum > SUM_W'(STOCK_MAX)) return {1'b1, STOCK_W'(STOCK_MAX)};
      return {1'b0, sum[STOCK_W-1:0]};
    end
    if (amt > cur) return {1'b1, STOCK_W'(0)};
    return {1'b0, cur - amt};
  endfunction

  assign w_level    = r_stock[i_wr_type];
  assign w_update   = sat_update(w_level, i_wr_amount, i_wr_add);
  assign o_wr_level = w_level;
  assign o_wr_clamp = w_update[STOCK_W];
  assign o_rd_data  = r_stock[i_rd_type];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TYPES; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
    end else if (i_wr_en) begin
      r_stock[i_wr_type] <= w_update[STOCK_W-1:0];
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - buy/restock transaction FSM; VEND_REVENUE_EN adds revenue and sales_count
module vend_sequencer
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       buy_req,
  input  logic [2:0] buy_type,
  input  logic [3:0] buy_amount,
  input  logic [6:0] customer_money,
  input  logic       restock_req,
  input  logic [2:0] restock_type,
  input  logic [3:0] restock_amount,
  output logic       ack,
  output logic       busy,
  output logic       done,
  output logic       dispense_valid,
  output logic [2:0] dispense_type,
  output logic [3:0] dispense_count,
  output logic [6:0] change,
  output logic [6:0] error,
  output logic [3:0] stock_level
`ifdef VEND_REVENUE_EN
  ,
  output logic [15:0] revenue,
  output logic [7:0]  sales_count
`endif
);

  state_t      r_state;
  logic        r_is_buy;
  logic [2:0]  r_type;
  logic [3:0]  r_amount;
  logic [6:0]  r_money;
  logic        r_ack;
  logic        r_done;
  logic        r_disp_valid;
  logic [2:0]  r_disp_type;
  logic [3:0]  r_disp_count;
  logic [6:0]  r_change;
  logic [6:0]  r_error;

  logic [10:0] w_cost;
  logic [6:0]  w_check_err;
  logic [3:0]  w_level;
  logic        w_clamp;
  logic        w_commit;

  assign w_cost   = {4'b0, price(r_type)} * {7'b0, r_amount};
  assign w_commit = (r_state == ST_COMMIT);

  vend_stock_bank u_stock (
    .clk         (clk),
    .rst         (rst),
    .i_rd_type   (buy_type),
    .o_rd_data   (stock_level),
    .i_wr_en     (w_commit),
    .i_wr_add    (!r_is_buy),
    .i_wr_type   (r_type),
    .i_wr_amount (r_amount),
    .o_wr_level  (w_level),
    .o_wr_clamp  (w_clamp)
  );

  always_comb begin
    w_check_err = '0;
    if (r_amount == 4'd0) w_check_err[ERR_ZERO_AMT] = 1'b1;
    if (r_is_buy) begin
      if (r_amount > w_level) w_check_err[ERR_NO_STOCK] = 1'b1;
      if (w_cost > {4'b0, r_money}) w_check_err[ERR_NO_MONEY] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_is_buy     <= 1'b0;
      r_type       <= '0;
      r_amount     <= '0;
      r_money      <= '0;
      r_ack        <= 1'b0;
      r_done       <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_type  <= '0;
      r_disp_count <= '0;
      r_change     <= '0;
      r_error      <= '0;
    end else begin
      r_ack        <= 1'b0;
      r_done       <= 1'b0;
      r_disp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Restock wins; a simultaneous buy stays pending on its level request.
          if (restock_req || buy_req) begin
            r_ack    <= 1'b1;
            r_is_buy <= !restock_req;
            r_type   <= restock_req ? restock_type : buy_type;
            r_amount <= restock_req ? restock_amount : buy_amount;
            r_money  <= restock_req ? 7'd0 : customer_money;
            r_change <= '0;
            r_error  <= (restock_req && buy_req) ? 7'(1 << ERR_COLLIDE) : 7'd0;
            r_state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_error <= r_error | w_check_err;
          r_state <= (w_check_err != 7'd0) ? ST_FAIL : ST_COMMIT;
        end
        ST_COMMIT: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
          if (r_is_buy) begin
            r_disp_valid <= 1'b1;
            r_disp_type  <= r_type;
            r_disp_count <= r_amount;
            r_change     <= r_money - w_cost[6:0];
          end else if (w_clamp) begin
            r_error[ERR_CLAMP] <= 1'b1;
          end
        end
        ST_FAIL: begin
          r_done   <= 1'b1;
          r_change <= r_is_buy ? r_money : 7'd0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef VEND_REVENUE_EN
  logic [15:0] r_revenue;
  logic [7:0]  r_sales_count;
  logic [16:0] w_rev_sum;

  assign w_rev_sum = {1'b0, r_revenue} + {6'b0, w_cost};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_revenue     <= '0;
      r_sales_count <= '0;
    end else if (w_commit && r_is_buy) begin
      r_revenue     <= w_rev_sum[16] ? 16'hFFFF : w_rev_sum[15:0];
      r_sales_count <= r_sales_count + 8'd1;
    end
  end

  assign revenue     = r_revenue;
  assign sales_count = r_sales_count;
`endif

  assign ack            = r_ack;
  assign busy           = (r_state != ST_IDLE);
  assign done           = r_done;
  assign dispense_valid = r_disp_valid;
  assign dispense_type  = r_disp_type;
  assign dispense_count = r_disp_count;
  assign change         = r_change;
  assign error          = r_error;

endmodule
